seq_binary_to_bcd: RTL and testbench

- Parametrised sequential successor to the combinational binary-to-BCD converter used by the calculator display path.
- Converts a WIDTH-bit binary operand into DIGITS packed BCD digits using shift-add-3 (double dabble), one bit per clock.
- Uses valid/ready handshakes on input and output, so it sits between the ALU result register and the 7-segment display driver.
- Flags results that do not fit in DIGITS digits.

---
 rtl/seq_binary_to_bcd.sv | 152 +++++++++++++++
 tb/tb_seq_binary_to_bcd.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_binary_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter; one operand bit per clock, valid/ready on both sides.
// Optional macro BCD_SIGNED_EN: two's-complement operand, magnitude converted, sign on 'negative'.
module seq_binary_to_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      number,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BCD_SIGNED_EN
    ,
    output logic                  negative
`endif
);

    localparam int unsigned AW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    adj;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] operand;
`ifdef BCD_SIGNED_EN
    logic             neg_acc_q, neg_acc_d;
    logic             negative_q, negative_d;
`endif

`ifdef BCD_SIGNED_EN
    // Magnitude as WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
    assign operand = number[WIDTH-1] ? ((~number) + WIDTH'(1)) : number;
`else
    assign operand = number;
`endif

    always_comb begin
        adj = acc_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
`ifdef BCD_SIGNED_EN
        neg_acc_d   = neg_acc_q;
        negative_d  = negative_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d      = operand;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
`ifdef BCD_SIGNED_EN
                    neg_acc_d = number[WIDTH-1];
`endif
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Any carry out of the top digit means the value needs more than DIGITS digits.
                acc_d     = {adj[AW-2:0], sr_q[WIDTH-1]};
                sr_d      = sr_q << 1;
                ovf_acc_d = ovf_acc_q | adj[AW-1];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d       = acc_d;
                    overflow_d  = ovf_acc_d;
                    out_valid_d = 1'b1;
`ifdef BCD_SIGNED_EN
                    negative_d  = neg_acc_q;
`endif
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg_acc_q   <= 1'b0;
            negative_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
`ifdef BCD_SIGNED_EN
            neg_acc_q   <= neg_acc_d;
            negative_q  <= negative_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign overflow  = overflow_q;
`ifdef BCD_SIGNED_EN
    assign negative  = negative_q;
`endif

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Scoreboard bench for seq_binary_to_bcd: two instances (3 and 2 digits), arithmetic reference model.
module tb_seq_binary_to_bcd;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, ovf_a;
    logic [7:0]   number_a;
    logic [11:0]  bcd_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b;
    logic [7:0]   number_b;
    logic [7:0]   bcd_b;
`ifdef BCD_SIGNED_EN
    logic         neg_a, neg_b;
`endif

    seq_binary_to_bcd #(.WIDTH(W), .DIGITS(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .number(number_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .bcd(bcd_a), .overflow(ovf_a)
`ifdef BCD_SIGNED_EN
        , .negative(neg_a)
`endif
    );

    seq_binary_to_bcd #(.WIDTH(W), .DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .number(number_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .bcd(bcd_b), .overflow(ovf_b)
`ifdef BCD_SIGNED_EN
        , .negative(neg_b)
`endif
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic        neg;
        int unsigned due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t cur_a, cur_b;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    int unsigned mode_a = 0;  // 0: always ready, 1: never ready, 2: random
    int unsigned mode_b = 0;

    // Reference: decimal digits of the (magnitude of the) value by division.
    function automatic exp_t model(input logic [7:0] n, input int unsigned digits, input int unsigned due);
        exp_t e;
        int unsigned v;
        int unsigned lim;
`ifdef BCD_SIGNED_EN
        e.neg = n[7];
        v = n[7] ? (256 - int'(n)) : int'(n);
`else
        e.neg = 1'b0;
        v = int'(n);
`endif
        lim = 10 ** digits;
        e.ovf = (v >= lim);
        v = v % lim;
        e.bcd = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        e.due = due;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        out_ready_a = (mode_a == 0) ? 1'b1 : (mode_a == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        out_ready_b = (mode_b == 0) ? 1'b1 : (mode_b == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_a = 1'b0;
        end else begin
            if (out_valid_a && !prev_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_spurious: out_valid=1 bcd=%h, expected no result", bcd_a);
                end else begin
                    cur_a = qa.pop_front();
                    check("a_latency", cyc, cur_a.due);
                    check("a_bcd", 32'(bcd_a), 32'(cur_a.bcd[11:0]));
                    check("a_ovf", 32'(ovf_a), 32'(cur_a.ovf));
`ifdef BCD_SIGNED_EN
                    check("a_neg", 32'(neg_a), 32'(cur_a.neg));
`endif
                end
            end else if (out_valid_a) begin
                check("a_hold_bcd", 32'(bcd_a), 32'(cur_a.bcd[11:0]));
                check("a_hold_ovf", 32'(ovf_a), 32'(cur_a.ovf));
            end
            prev_a = out_valid_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_b = 1'b0;
        end else begin
            if (out_valid_b && !prev_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_spurious: out_valid=1 bcd=%h, expected no result", bcd_b);
                end else begin
                    cur_b = qb.pop_front();
                    check("b_latency", cyc, cur_b.due);
                    check("b_bcd", 32'(bcd_b), 32'(cur_b.bcd[7:0]));
                    check("b_ovf", 32'(ovf_b), 32'(cur_b.ovf));
`ifdef BCD_SIGNED_EN
                    check("b_neg", 32'(neg_b), 32'(cur_b.neg));
`endif
                end
            end else if (out_valid_b) begin
                check("b_hold_bcd", 32'(bcd_b), 32'(cur_b.bcd[7:0]));
            end
            prev_b = out_valid_b;
        end
    end

    task automatic send_a(input logic [7:0] n);
        int unsigned t = 0;
        @(negedge clk);
        while (!in_ready_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_a) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: in_ready=0 after %0d cycles, required 1", t);
            return;
        end
        in_valid_a = 1'b1;
        number_a   = n;
        qa.push_back(model(n, 3, cyc + 1 + W));
        @(negedge clk);
        in_valid_a = 1'b0;
        number_a   = 8'($urandom);
    endtask

    task automatic send_b(input logic [7:0] n);
        int unsigned t = 0;
        @(negedge clk);
        while (!in_ready_b && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_b) begin
            checks++;
            errors++;
            $display("FAIL b_accept_timeout: in_ready=0 after %0d cycles, required 1", t);
            return;
        end
        in_valid_b = 1'b1;
        number_b   = n;
        qb.push_back(model(n, 2, cyc + 1 + W));
        @(negedge clk);
        in_valid_b = 1'b0;
        number_b   = 8'($urandom);
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((qa.size() != 0 || out_valid_a || qb.size() != 0 || out_valid_b) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0", qa.size(), qb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        exp_t e57;
        int unsigned t;
        logic [7:0] dir_a[11] = '{8'hEF, 8'h6F, 8'hFF, 8'd0, 8'd100, 8'd9, 8'h80, 8'h7F, 8'd1, 8'd10, 8'd99};
        logic [7:0] dir_b[5]  = '{8'd255, 8'd99, 8'd0, 8'd100, 8'h80};

        rst_n      = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        number_a   = '0;
        number_b   = '0;
        #2;
        check("rst_a_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_a_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_a_bcd", 32'(bcd_a), 32'd0);
        check("rst_a_ovf", 32'(ovf_a), 32'd0);
        check("rst_b_in_ready", 32'(in_ready_b), 32'd1);
        check("rst_b_out_valid", 32'(out_valid_b), 32'd0);
        check("rst_b_bcd", 32'(bcd_b), 32'd0);
        check("rst_b_ovf", 32'(ovf_b), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (dir_a[i]) send_a(dir_a[i]);
        foreach (dir_b[i]) send_b(dir_b[i]);
        drain();

        // Backpressure: hold the result, ignore new operands, then release.
        @(negedge clk);
        #1 mode_a = 1;
        send_a(8'd57);
        e57 = model(8'd57, 3, 0);
        t = 0;
        while (!out_valid_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_rise", 32'(out_valid_a), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid_a = 1'b1;
            number_a   = 8'd1;
            check("bp_out_valid", 32'(out_valid_a), 32'd1);
            check("bp_bcd", 32'(bcd_a), 32'(e57.bcd[11:0]));
            check("bp_in_ready", 32'(in_ready_a), 32'd0);
        end
        #1;
        in_valid_a = 1'b0;
        mode_a     = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 32'(out_valid_a), 32'd0);
        check("bp_release_in_ready", 32'(in_ready_a), 32'd1);
        drain();

        // Random operands with random consumer stalls.
        mode_a = 2;
        mode_b = 2;
        for (int i = 0; i < 150; i++) send_a(8'($urandom));
        for (int i = 0; i < 100; i++) send_b(8'($urandom));
        drain();
        mode_a = 0;
        mode_b = 0;

        // Asynchronous reset in the middle of a conversion.
        send_a(8'd200);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
        check("mid_rst_bcd", 32'(bcd_a), 32'd0);
        check("mid_rst_ovf", 32'(ovf_a), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_a), 32'd1);
        qa.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_a(8'd42);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
